// File: rtl/matrix_job_sequencer_if.sv
// rtl/matrix_job_sequencer_if.sv - command, memory, coprocessor and response bundle for matrix_job_sequencer
interface matrix_job_sequencer_if #(
  parameter int N_ELEM = 25,
  parameter int ADDR_W = 7
);
  // command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [7:0]            cmd_scalar;
  logic [ADDR_W-1:0]     cmd_src_base;
  logic [ADDR_W-1:0]     cmd_dst_base;

  // single-port operand/result memory
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_wren;
  logic [15:0]           mem_wdata;
  logic [15:0]           mem_rdata;

  // matrix coprocessor
  logic [2:0]            cop_op;
  logic [7:0]            cop_scalar;
  logic [8*N_ELEM-1:0]   cop_matrix_a;
  logic [8*N_ELEM-1:0]   cop_matrix_b;
  logic                  cop_start;
  logic                  cop_done;
  logic [8*N_ELEM-1:0]   cop_result;
  logic                  cop_overflow;

  // response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_overflow;
  logic                  rsp_timeout;

  // status
  logic                  busy;
  logic [2:0]            state_dbg;

  // sequencer side
  modport master (
    input  cmd_valid, cmd_op, cmd_scalar, cmd_src_base, cmd_dst_base,
    output cmd_ready,
    output mem_addr, mem_wren, mem_wdata,
    input  mem_rdata,
    output cop_op, cop_scalar, cop_matrix_a, cop_matrix_b, cop_start,
    input  cop_done, cop_result, cop_overflow,
    output rsp_valid, rsp_overflow, rsp_timeout,
    input  rsp_ready,
    output busy, state_dbg
  );

  // host, memory and coprocessor side
  modport slave (
    output cmd_valid, cmd_op, cmd_scalar, cmd_src_base, cmd_dst_base,
    input  cmd_ready,
    input  mem_addr, mem_wren, mem_wdata,
    output mem_rdata,
    input  cop_op, cop_scalar, cop_matrix_a, cop_matrix_b, cop_start,
    output cop_done, cop_result, cop_overflow,
    input  rsp_valid, rsp_overflow, rsp_timeout,
    output rsp_ready,
    input  busy, state_dbg
  );
endinterface

// File: rtl/matrix_job_sequencer.sv
// rtl/matrix_job_sequencer.sv - job sequencer feeding the 5x5 matrix coprocessor from a 128x16 memory
module matrix_job_sequencer #(
  parameter int N_ELEM      = 25,
  parameter int ADDR_W      = 7,
  parameter int RD_LAT      = 1,
  parameter int CALC_CYCLES = 70
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_job_sequencer_if.master bus
);
  localparam int MAT_W    = 8 * N_ELEM;
  localparam int RD_TOTAL = N_ELEM + RD_LAT;
  localparam int CNT_MAX  = (CALC_CYCLES > RD_TOTAL) ? CALC_CYCLES : RD_TOTAL;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CALC  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  src_base;
  logic [ADDR_W-1:0]  dst_base;
  logic [2:0]         op_q;
  logic [7:0]         scalar_q;
  logic [MAT_W-1:0]   mat_a;
  logic [MAT_W-1:0]   mat_b;
  logic [MAT_W-1:0]   res_sh;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               mem_wren_q;
  logic [15:0]        mem_wdata_q;
  logic               cop_start_q;
  logic               rsp_valid_q;
  logic               rsp_ovf_q;
  logic               rsp_to_q;

  // One shared counter walks READ cycles, CALC budget and WRITE elements.
  // The next element's address offset is cnt+1, wrapped to the address width
  // so that bases near the top of memory roll over to 0.
  logic [CNT_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]  addr_off;
  logic               calc_exit;

  assign cnt_inc   = cnt + CNT_W'(1);
  assign addr_off  = ADDR_W'(cnt_inc);
  assign calc_exit = bus.cop_done || (cnt == CNT_W'(CALC_CYCLES - 1));

  // Job FSM: accept, stream operands in, run coprocessor, stream results out, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      src_base    <= '0;
      dst_base    <= '0;
      op_q        <= '0;
      scalar_q    <= '0;
      mat_a       <= '0;
      mat_b       <= '0;
      res_sh      <= '0;
      mem_addr_q  <= '0;
      mem_wren_q  <= 1'b0;
      mem_wdata_q <= '0;
      cop_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q       <= bus.cmd_op;
            scalar_q   <= bus.cmd_scalar;
            src_base   <= bus.cmd_src_base;
            dst_base   <= bus.cmd_dst_base;
            mem_addr_q <= bus.cmd_src_base;
            cnt        <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
            state      <= S_READ;
          end
        end

        S_READ: begin
          // Data for the address issued RD_LAT cycles ago is on mem_rdata now.
          // Shifting in from the top leaves element 0 at bits [7:0] after the
          // last capture.
          if (cnt >= CNT_W'(RD_LAT)) begin
            mat_a <= {bus.mem_rdata[7:0],  mat_a[MAT_W-1:8]};
            mat_b <= {bus.mem_rdata[15:8], mat_b[MAT_W-1:8]};
          end
          if (cnt < CNT_W'(N_ELEM - 1)) begin
            mem_addr_q <= src_base + addr_off;
          end else begin
            mem_addr_q <= '0;
          end
          if (cnt == CNT_W'(RD_TOTAL - 1)) begin
            cnt         <= '0;
            cop_start_q <= 1'b1;
            state       <= S_CALC;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_CALC: begin
          // done takes priority over the budget when both land together
          if (calc_exit) begin
            rsp_to_q    <= ~bus.cop_done;
            rsp_ovf_q   <= bus.cop_overflow;
            res_sh      <= bus.cop_result >> 8;
            mem_wdata_q <= {8'h00, bus.cop_result[7:0]};
            mem_addr_q  <= dst_base;
            mem_wren_q  <= 1'b1;
            cop_start_q <= 1'b0;
            cnt         <= '0;
            state       <= S_WRITE;
          end else begin
            cnt <= cnt_inc;
          end
        end

        S_WRITE: begin
          if (cnt == CNT_W'(N_ELEM - 1)) begin
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt         <= '0;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else begin
            cnt         <= cnt_inc;
            mem_addr_q  <= dst_base + addr_off;
            mem_wdata_q <= {8'h00, res_sh[7:0]};
            res_sh      <= res_sh >> 8;
          end
        end

        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready    = (state == S_IDLE);
  assign bus.busy         = (state != S_IDLE);
  assign bus.state_dbg    = state;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wren     = mem_wren_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.cop_op       = op_q;
  assign bus.cop_scalar   = scalar_q;
  assign bus.cop_matrix_a = mat_a;
  assign bus.cop_matrix_b = mat_b;
  assign bus.cop_start    = cop_start_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_timeout  = rsp_to_q;
endmodule
